// File: rtl/fm_pkg.sv
// Shared widths, state encoding and output payload layout for the FM channel sequencer.
package fm_pkg;

  localparam int NUM_CH_DEF = 18;
  localparam int CH_W       = 5;
  localparam int FNUM_W     = 10;
  localparam int BLOCK_W    = 3;
  localparam int FB_W       = 3;
  localparam int PHINC_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic [PHINC_W-1:0] phinc;
    logic [FB_W-1:0]    fb;
    logic               cnt;
    logic               cha;
    logic               chb;
    logic               kon;
    logic               kon_rise;
    logic               kon_fall;
  } out_pl_t;

endpackage

// File: rtl/fm_ch_seq_if.sv
// Valid/ready channel stream from the sequencer to the operator stage.
interface fm_ch_seq_if;
  import fm_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [CH_W-1:0]    out_ch;
  logic [PHINC_W-1:0] out_phinc;
  logic [FB_W-1:0]    out_fb;
  logic               out_cnt;
  logic               out_cha;
  logic               out_chb;
  logic               out_kon;
  logic               out_kon_rise;
  logic               out_kon_fall;

  modport master (
    output out_valid, out_ch, out_phinc, out_fb, out_cnt, out_cha, out_chb,
           out_kon, out_kon_rise, out_kon_fall,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ch, out_phinc, out_fb, out_cnt, out_cha, out_chb,
           out_kon, out_kon_rise, out_kon_fall,
    output out_ready
  );
endinterface

// File: rtl/fm_phinc.sv
// fm_phinc: converts fnum/block into a phase increment, (fnum << block) >> 1.
// Latency: combinational.
// Backpressure: none.
module fm_phinc
  import fm_pkg::*;
(
  input  logic [FNUM_W-1:0]  fnum,
  input  logic [BLOCK_W-1:0] block,
  output logic [PHINC_W-1:0] phinc
);

  // One spare bit so block=7 keeps the MSB before the halving shift.
  logic [PHINC_W:0] shifted;

  assign shifted = {{(PHINC_W + 1 - FNUM_W){1'b0}}, fnum} << block;
  assign phinc   = PHINC_W'(shifted >> 1);

endmodule

// File: rtl/fm_ch_seq.sv
// fm_ch_seq: per sample, sweeps NUM_CH channel attributes into an output stream; FM_CH_SEQ_KON_EDGE_EN adds key-on edges.
// Latency: strobe at cycle T -> channel 0 valid at T+2, then one channel per cycle.
// Backpressure: output register holds while out_ready is low and the sweep stalls with it.
module fm_ch_seq
  import fm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_strobe,
  output logic [CH_W-1:0]    ch_sel,
  input  logic               ch_chb,
  input  logic               ch_cha,
  input  logic               ch_cnt,
  input  logic               ch_kon,
  input  logic [FB_W-1:0]    ch_fb,
  input  logic [BLOCK_W-1:0] ch_block,
  input  logic [FNUM_W-1:0]  ch_fnum,
  fm_ch_seq_if.master        out_if,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t             state_q, state_d;
  logic [CH_W-1:0]    scan_q, scan_d;
  logic               out_valid_q, out_valid_d;
  out_pl_t            pl_q, pl_d, cap_pl;
  logic [PHINC_W-1:0] phinc;
  logic               kon_rise, kon_fall;
  logic               fire, take;

  fm_phinc u_phinc (
    .fnum  (ch_fnum),
    .block (ch_block),
    .phinc (phinc)
  );

  assign fire = out_valid_q && out_if.out_ready;
  // The output register accepts new data when empty or drained this cycle.
  assign take = (state_q == ST_RUN) && (!out_valid_q || out_if.out_ready);

`ifdef FM_CH_SEQ_KON_EDGE_EN
  logic [NUM_CH-1:0] prev_kon_q, prev_kon_d;

  assign kon_rise = ch_kon && !prev_kon_q[scan_q];
  assign kon_fall = !ch_kon && prev_kon_q[scan_q];

  always_comb begin
    prev_kon_d = prev_kon_q;
    if (take) begin
      prev_kon_d[scan_q] = ch_kon;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_kon_q <= '0;
    end else begin
      prev_kon_q <= prev_kon_d;
    end
  end
`else
  assign kon_rise = 1'b0;
  assign kon_fall = 1'b0;
`endif

  always_comb begin
    cap_pl          = '0;
    cap_pl.ch       = scan_q;
    cap_pl.phinc    = phinc;
    cap_pl.fb       = ch_fb;
    cap_pl.cnt      = ch_cnt;
    cap_pl.cha      = ch_cha;
    cap_pl.chb      = ch_chb;
    cap_pl.kon      = ch_kon;
    cap_pl.kon_rise = kon_rise;
    cap_pl.kon_fall = kon_fall;
  end

  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    out_valid_d = out_valid_q;
    pl_d        = pl_q;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_strobe) begin
          state_d = ST_RUN;
          scan_d  = '0;
        end
      end
      ST_RUN: begin
        if (take) begin
          pl_d        = cap_pl;
          out_valid_d = 1'b1;
          // Scan index parks on the last channel so ch_sel holds through DRAIN/IDLE.
          if (scan_q == LAST_CH) begin
            state_d = ST_DRAIN;
          end else begin
            scan_d = scan_q + CH_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (fire) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          done        = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      scan_q      <= '0;
      out_valid_q <= 1'b0;
      pl_q        <= '0;
    end else begin
      state_q     <= state_d;
      scan_q      <= scan_d;
      out_valid_q <= out_valid_d;
      pl_q        <= pl_d;
    end
  end

  assign ch_sel  = scan_q;
  assign busy    = (state_q != ST_IDLE);
  assign overrun = sample_strobe && busy;

  assign out_if.out_valid    = out_valid_q;
  assign out_if.out_ch       = pl_q.ch;
  assign out_if.out_phinc    = pl_q.phinc;
  assign out_if.out_fb       = pl_q.fb;
  assign out_if.out_cnt      = pl_q.cnt;
  assign out_if.out_cha      = pl_q.cha;
  assign out_if.out_chb      = pl_q.chb;
  assign out_if.out_kon      = pl_q.kon;
  assign out_if.out_kon_rise = pl_q.kon_rise;
  assign out_if.out_kon_fall = pl_q.kon_fall;

endmodule

// File: tb/tb_fm_ch_seq.sv
// Scoreboard bench for fm_ch_seq: sweeps, backpressure, key-on edges, overrun and mid-sweep reset.
module tb_fm_ch_seq;
  import fm_pkg::*;

  localparam int NCH = 18;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               sample_strobe;
  logic [CH_W-1:0]    ch_sel;
  logic               ch_chb, ch_cha, ch_cnt, ch_kon;
  logic [FB_W-1:0]    ch_fb;
  logic [BLOCK_W-1:0] ch_block;
  logic [FNUM_W-1:0]  ch_fnum;
  logic               busy, done, overrun;

  fm_ch_seq_if dut_if ();

  fm_ch_seq #(.NUM_CH(NCH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_strobe (sample_strobe),
    .ch_sel        (ch_sel),
    .ch_chb        (ch_chb),
    .ch_cha        (ch_cha),
    .ch_cnt        (ch_cnt),
    .ch_kon        (ch_kon),
    .ch_fb         (ch_fb),
    .ch_block      (ch_block),
    .ch_fnum       (ch_fnum),
    .out_if        (dut_if),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Attribute RAM model, read combinationally at ch_sel.
  logic [FNUM_W-1:0]  a_fnum  [32];
  logic [BLOCK_W-1:0] a_block [32];
  logic [FB_W-1:0]    a_fb    [32];
  logic               a_cnt [32], a_cha [32], a_chb [32], a_kon [32];

  assign ch_fnum  = a_fnum[ch_sel];
  assign ch_block = a_block[ch_sel];
  assign ch_fb    = a_fb[ch_sel];
  assign ch_cnt   = a_cnt[ch_sel];
  assign ch_cha   = a_cha[ch_sel];
  assign ch_chb   = a_chb[ch_sel];
  assign ch_kon   = a_kon[ch_sel];

  out_pl_t exp_q[$];
  out_pl_t mon_exp, mon_act;
  int      n_chk = 0, n_pass = 0, n_fail = 0;
  int      ovr_cnt = 0;
`ifdef FM_CH_SEQ_KON_EDGE_EN
  logic    m_prev [NCH];
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_phinc(input int i);
    int v;
    if (i == 0) return 16'hFFC0;
    if (i == 1) return 16'h00AA;
    v = int'(a_fnum[i]) * (2 ** int'(a_block[i])) / 2;
    return 16'(v);
  endfunction

  task automatic push_sweep();
    for (int i = 0; i < NCH; i++) begin
      out_pl_t e;
      e          = '0;
      e.ch       = 5'(i);
      e.phinc    = exp_phinc(i);
      e.fb       = a_fb[i];
      e.cnt      = a_cnt[i];
      e.cha      = a_cha[i];
      e.chb      = a_chb[i];
      e.kon      = a_kon[i];
`ifdef FM_CH_SEQ_KON_EDGE_EN
      e.kon_rise = a_kon[i] && !m_prev[i];
      e.kon_fall = !a_kon[i] && m_prev[i];
      m_prev[i]  = a_kon[i];
`endif
      exp_q.push_back(e);
    end
  endtask

  task automatic start_sweep();
    @(posedge clk); #1 sample_strobe = 1'b1;
    push_sweep();
    @(posedge clk); #1 sample_strobe = 1'b0;
  endtask

  task automatic wait_ch(input int ch, input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (dut_if.out_valid && dut_if.out_ch == 5'(ch)) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (reset_n && dut_if.out_valid && dut_if.out_ready) begin
      mon_act          = '0;
      mon_act.ch       = dut_if.out_ch;
      mon_act.phinc    = dut_if.out_phinc;
      mon_act.fb       = dut_if.out_fb;
      mon_act.cnt      = dut_if.out_cnt;
      mon_act.cha      = dut_if.out_cha;
      mon_act.chb      = dut_if.out_chb;
      mon_act.kon      = dut_if.out_kon;
      mon_act.kon_rise = dut_if.out_kon_rise;
      mon_act.kon_fall = dut_if.out_kon_fall;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got ch %0d with empty scoreboard at %0t", mon_act.ch, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        n_chk++;
        if (mon_act === mon_exp) begin
          n_pass++;
        end else begin
          n_fail++;
          $display("FAIL payload: got %h expected %h (ch %0d) at %0t",
                   mon_act, mon_exp, mon_exp.ch, $time);
        end
        chk("done_on_beat", 32'(done), 32'(mon_exp.ch == 5'(NCH - 1)));
      end
    end
  end

  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int ovr_base;
    reset_n          = 1'b0;
    sample_strobe    = 1'b0;
    dut_if.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_fnum[i]  = 10'((i * 73 + 11) % 1024);
      a_block[i] = 3'(i % 8);
      a_fb[i]    = 3'((i * 3) % 8);
      a_cnt[i]   = (i % 2) == 1;
      a_cha[i]   = (i % 3) == 0;
      a_chb[i]   = (i % 5) == 0;
      a_kon[i]   = (i == 5) || (i == 11);
    end
    a_fnum[0] = 10'h3FF; a_block[0] = 3'd7;
    a_fnum[1] = 10'h155; a_block[1] = 3'd0;
`ifdef FM_CH_SEQ_KON_EDGE_EN
    for (int i = 0; i < NCH; i++) m_prev[i] = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(dut_if.out_valid), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_overrun",   32'(overrun), 32'd0);
    chk("rst_ch_sel",    32'(ch_sel), 32'd0);
    chk("rst_out_ch",    32'(dut_if.out_ch), 32'd0);
    chk("rst_out_phinc", 32'(dut_if.out_phinc), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Sweep 1: latency and full-rate throughput
    @(posedge clk); #1 sample_strobe = 1'b1;
    push_sweep();
    @(negedge clk);
    chk("idle_strobe_overrun", 32'(overrun), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 sample_strobe = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", 32'(dut_if.out_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t2_out_valid", 32'(dut_if.out_valid), 32'd1);
    chk("t2_out_ch", 32'(dut_if.out_ch), 32'd0);
    cnt = 0;
    while (!done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("sweep_cycles", 32'(cnt), 32'd17);
    @(negedge clk);
    chk("post_done_busy", 32'(busy), 32'd0);
    chk("post_done_valid", 32'(dut_if.out_valid), 32'd0);
    chk("sweep1_drained", 32'(exp_q.size()), 32'd0);

    // Sweep 2: ch2 key-on rises, 5-cycle stall on ch3
    a_kon[2] = 1'b1;
    start_sweep();
    wait_ch(2, "wait_ch2");
    @(posedge clk); #1 dut_if.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(dut_if.out_valid), 32'd1);
      chk("stall_ch",    32'(dut_if.out_ch), 32'd3);
      chk("stall_phinc", 32'(dut_if.out_phinc), 32'(exp_phinc(3)));
      chk("stall_fb",    32'(dut_if.out_fb), 32'(a_fb[3]));
    end
    @(posedge clk); #1 dut_if.out_ready = 1'b1;
    wait_done("sweep2_done");
    @(negedge clk);
    chk("sweep2_busy", 32'(busy), 32'd0);
    chk("sweep2_drained", 32'(exp_q.size()), 32'd0);

    // Sweep 3: ch11 key-on falls, strobe at ch9 is an overrun
    a_kon[11] = 1'b0;
    ovr_base = ovr_cnt;
    start_sweep();
    wait_ch(9, "wait_ch9");
    @(posedge clk); #1 sample_strobe = 1'b1;
    @(negedge clk);
    chk("overrun_pulse", 32'(overrun), 32'd1);
    @(posedge clk); #1 sample_strobe = 1'b0;
    @(negedge clk);
    chk("overrun_clear", 32'(overrun), 32'd0);
    wait_done("sweep3_done");
    @(negedge clk);
    chk("overrun_count", 32'(ovr_cnt - ovr_base), 32'd1);
    chk("sweep3_busy", 32'(busy), 32'd0);
    chk("sweep3_drained", 32'(exp_q.size()), 32'd0);

    // Sweep 4: strobe in the done cycle starts nothing
    start_sweep();
    wait_ch(16, "wait_ch16");
    @(posedge clk); #1 sample_strobe = 1'b1;
    @(negedge clk);
    chk("done_cycle_done", 32'(done), 32'd1);
    chk("done_cycle_overrun", 32'(overrun), 32'd1);
    @(posedge clk); #1 sample_strobe = 1'b0;
    @(negedge clk);
    chk("done_cycle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("no_restart_valid", 32'(dut_if.out_valid), 32'd0);
    chk("no_restart_busy", 32'(busy), 32'd0);
    chk("sweep4_drained", 32'(exp_q.size()), 32'd0);

    // Sweep 5: reset at ch7, then an immediate fresh sweep
    start_sweep();
    wait_ch(7, "wait_ch7");
    #1 reset_n = 1'b0;
    exp_q.delete();
`ifdef FM_CH_SEQ_KON_EDGE_EN
    for (int i = 0; i < NCH; i++) m_prev[i] = 1'b0;
`endif
    #1;
    chk("midrst_valid", 32'(dut_if.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ch_sel", 32'(ch_sel), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    start_sweep();
    wait_done("sweep6_done");
    @(negedge clk);
    chk("sweep6_busy", 32'(busy), 32'd0);
    chk("sweep6_drained", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fm_ch_seq.md
FM_CH_SEQ -- requirements
Module: fm_ch_seq

Interface
REQ-001 Parameter NUM_CH, default 18, number of channels swept per sample (1..32).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 sample_strobe  input  1  one-cycle pulse starting one channel sweep.
REQ-005 ch_sel  output  5  channel index to the attribute RAM read port.
REQ-006 ch_chb, ch_cha, ch_cnt, ch_kon  input  1 each  attributes for ch_sel; combinational, same cycle.
REQ-007 ch_fb  input  3; ch_block  input  3; ch_fnum  input  10  attributes for ch_sel.
REQ-008 out_valid  output  1; out_ready  input  1  valid/ready handshake to the operator stage.
REQ-009 out_ch  output  5; out_phinc  output  16; out_fb  output  3.
REQ-010 out_cnt, out_cha, out_chb, out_kon, out_kon_rise, out_kon_fall  output  1 each.
REQ-011 busy  output  1  high while a sweep is in progress; done  output  1  one-cycle pulse at sweep end.
REQ-012 overrun  output  1  one-cycle pulse when sample_strobe arrives while busy.

Function
REQ-013 States: IDLE, RUN, DRAIN; reset state IDLE.
REQ-014 IDLE: sample_strobe -> RUN, scan index = 0.
REQ-015 RUN: ch_sel = scan index; when the output register is empty or is consumed this cycle, capture the attributes into it, set out_valid, and increment the scan index.
REQ-016 RUN: after capturing channel NUM_CH-1 -> DRAIN.
REQ-017 DRAIN: when out_valid && out_ready -> IDLE, and done pulses in the same cycle.
REQ-018 Latency: strobe at cycle T gives out_valid with out_ch=0 at T+2; throughput is 1 channel/cycle with out_ready held high.
REQ-019 out_valid and every payload output hold stable while out_valid && !out_ready.
REQ-020 out_phinc = ({6'b0, fnum} << block) >> 1, truncated to 16 bits; no overflow is possible (max 65472).
REQ-021 out_kon_rise = kon && !prev_kon[ch]; out_kon_fall = !kon && prev_kon[ch]; prev_kon[ch] updates on capture.
REQ-022 sample_strobe when busy (RUN/DRAIN): ignored, overrun pulses, and the sweep continues unchanged.
REQ-023 Strobe coinciding with the done cycle: treated as overrun; no new sweep starts.
REQ-024 busy = (state != IDLE).
REQ-025 ch_sel holds its last value in IDLE and DRAIN.

Reset
REQ-026 Reset asserted at any time, mid-sweep included: state=IDLE, scan index=0, ch_sel=0, out_valid=0, payload outputs=0, prev_kon=0, done=0, overrun=0, busy=0.
REQ-027 Reset release requires no recovery cycles; the first strobe after release is honoured.

Configuration
REQ-028 Macro FM_CH_SEQ_KON_EDGE_EN defined: the per-channel prev_kon register (NUM_CH bits) and the REQ-021 logic are present.
REQ-029 Macro FM_CH_SEQ_KON_EDGE_EN undefined: out_kon_rise and out_kon_fall are tied to 0, no prev_kon storage exists, and all other behaviour is identical.

Structure
REQ-030 Shared package fm_pkg holds: NUM_CH default, FNUM_W=10, BLOCK_W=3, PHINC_W=16, and the state encoding constants.
REQ-031 One sub-module fm_phinc (combinational fnum/block to phase increment) is instantiated once.
REQ-032 No RAM is inside this block; attributes come solely through the ch_* ports.

Verification
REQ-033 Strobe with out_ready=1 and NUM_CH=18 -> out_ch 0..17 on consecutive cycles from T+2, done at the cycle of channel 17 acceptance, busy low the next cycle.
REQ-034 fnum=0x3FF, block=7 -> out_phinc=0xFFC0; fnum=0x155, block=0 -> out_phinc=0x00AA.
REQ-035 out_ready held low 5 cycles on channel 3 -> out_ch=3 and payload stable for those 5 cycles, no channel skipped or duplicated.
REQ-036 ch_kon for channel 2 goes 0->1 between sweeps -> out_kon_rise=1 for channel 2 only in the next sweep, and 0 in the following sweep; with the macro undefined, always 0.
REQ-037 Strobe at out_ch=9 mid-sweep -> overrun pulses once and the sweep completes 0..17 normally.
REQ-038 reset_n low at out_ch=7 -> out_valid=0 and busy=0 immediately; a new strobe restarts at ch 0 with all kon_rise computed against prev_kon=0.
